mem_stage: RTL and testbench

//  Memory stage, directly downstream of the execute stage. Consumes the EX/MEM-registered ALU result
//  (address or arithmetic value), store data and load/store controls. Runs a req/ack transaction to

---
 rtl/mem_stage_pkg.sv | 31 +++
 rtl/mem_stage_align.sv | 61 ++++++
 rtl/mem_stage.sv | 156 +++++++++++++++
 tb/tb_mem_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory stage: access sizes, FSM states and funct3 decode.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'd0,
        MEM_SIZE_H = 2'd1,
        MEM_SIZE_W = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_t;

    // funct3[2] set selects zero-extension (BU/HU)
    localparam int MEM_UNSIGNED_BIT = 2;
    localparam logic [31:0] MISALIGN_RESULT = 32'hbaad_beef;

    // Reserved encodings (011, 110, 111) behave as word accesses
    function automatic mem_size_t decode_size(input logic [2:0] funct3);
        mem_size_t size;
        case (funct3)
            3'b000, 3'b100: size = MEM_SIZE_B;
            3'b001, 3'b101: size = MEM_SIZE_H;
            default:        size = MEM_SIZE_W;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane logic: byte enables, store-data replication, misalign check, load extension.
module mem_stage_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic [31:0] ld_data
);

    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [31:0]        lane;
        logic signed [7:0]  lane_b;
        logic signed [15:0] lane_h;
        logic signed [31:0] ext;
        lane   = word >> {off, 3'b000};
        lane_b = lane[7:0];
        lane_h = lane[15:0];
        case (decode_size(f3))
            MEM_SIZE_B: begin
                if (f3[MEM_UNSIGNED_BIT]) ext = {24'b0, lane[7:0]};
                else                      ext = lane_b;
            end
            MEM_SIZE_H: begin
                if (f3[MEM_UNSIGNED_BIT]) ext = {16'b0, lane[15:0]};
                else                      ext = lane_h;
            end
            default: ext = lane;
        endcase
        return ext;
    endfunction

    always_comb begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = 1'b0;
        case (decode_size(funct3))
            MEM_SIZE_B: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            MEM_SIZE_H: begin
                be         = 4'b0011 << offset;
                wdata      = {2{store_data[15:0]}};
                misaligned = offset[0];
            end
            default: misaligned = |offset;
        endcase
    end

    assign ld_data = load_extend(ld_funct3, ld_offset, rdata);

endmodule

// File: rtl/mem_stage.sv
// Memory stage: req/ack handshake to data memory with pipeline stall, timeout abort and write-back mux.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_rega,
    input  logic [2:0]  ex_mem_funct3,
    input  logic        ex_mem_rd_mem,
    input  logic        ex_mem_wr_mem,
    input  logic        ex_mem_valid_inst,
    output logic        proc2mem_req,
    output logic        proc2mem_we,
    output logic [31:0] proc2mem_addr,
    output logic [31:0] proc2mem_wdata,
    output logic [3:0]  proc2mem_be,
    input  logic        mem2proc_ack,
    input  logic [31:0] mem2proc_rdata,
    output logic [31:0] mem_result_out,
    output logic        mem_stall_out,
    output logic        mem_misaligned_out,
    output logic        mem_bus_error_out
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    mem_state_t        state;
    logic              req_p1;
    logic              we_p1;
    logic              load_p1;
    logic [31:0]       addr_p1;
    logic [31:0]       wdata_p1;
    logic [3:0]        be_p1;
    logic [2:0]        funct3_p1;
    logic [1:0]        offset_p1;
    logic [CNT_W-1:0]  cnt_p1;
    logic              bus_err_p2;
    logic [31:0]       result_p2;

    logic              mem_op;
    logic              accept;
    logic              timeout_hit;
    logic [3:0]        align_be;
    logic [31:0]       align_wdata;
    logic              align_mis;
    logic [31:0]       ld_data;

    mem_stage_align u_align (
        .funct3     (ex_mem_funct3),
        .offset     (ex_mem_alu_result[1:0]),
        .store_data (ex_mem_rega),
        .ld_funct3  (funct3_p1),
        .ld_offset  (offset_p1),
        .rdata      (mem2proc_rdata),
        .be         (align_be),
        .wdata      (align_wdata),
        .misaligned (align_mis),
        .ld_data    (ld_data)
    );

    assign mem_op      = ex_mem_valid_inst & (ex_mem_rd_mem | ex_mem_wr_mem);
    assign accept      = (state == MEM_IDLE) & mem_op & ~align_mis;
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (state == MEM_BUSY) &&
                         !mem2proc_ack && (cnt_p1 == CNT_LAST);

    // Stage p1: request launch and hold, plus the ack/timeout control
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= MEM_IDLE;
            req_p1     <= 1'b0;
            we_p1      <= 1'b0;
            load_p1    <= 1'b0;
            addr_p1    <= '0;
            wdata_p1   <= '0;
            be_p1      <= '0;
            funct3_p1  <= '0;
            offset_p1  <= '0;
            cnt_p1     <= '0;
            bus_err_p2 <= 1'b0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (accept) begin
                        // A set rd_mem wins over wr_mem
                        load_p1    <= ex_mem_rd_mem;
                        we_p1      <= ~ex_mem_rd_mem;
                        addr_p1    <= {ex_mem_alu_result[31:2], 2'b00};
                        wdata_p1   <= align_wdata;
                        be_p1      <= align_be;
                        funct3_p1  <= ex_mem_funct3;
                        offset_p1  <= ex_mem_alu_result[1:0];
                        cnt_p1     <= '0;
                        bus_err_p2 <= 1'b0;
                        req_p1     <= 1'b1;
                        state      <= MEM_BUSY;
                    end
                end
                MEM_BUSY: begin
                    cnt_p1 <= cnt_p1 + 1'b1;
                    if (mem2proc_ack) begin
                        req_p1 <= 1'b0;
                        state  <= MEM_DONE;
                    end else if (timeout_hit) begin
                        req_p1     <= 1'b0;
                        bus_err_p2 <= 1'b1;
                        state      <= MEM_DONE;
                    end
                end
                MEM_DONE: state <= MEM_IDLE;
                default:  state <= MEM_IDLE;
            endcase
        end
    end

    // Stage p2: captured load result
    always_ff @(posedge clk) begin
        if (state == MEM_BUSY) begin
            if (mem2proc_ack && load_p1) result_p2 <= ld_data;
            else if (timeout_hit)        result_p2 <= '0;
        end
    end

    always_comb begin
        mem_stall_out      = 1'b0;
        mem_misaligned_out = 1'b0;
        mem_result_out     = ex_mem_alu_result;
        case (state)
            MEM_IDLE: begin
                if (mem_op) begin
                    if (align_mis) begin
                        mem_misaligned_out = 1'b1;
                        mem_result_out     = MISALIGN_RESULT;
                    end else begin
                        mem_stall_out = 1'b1;
                    end
                end
            end
            MEM_BUSY: mem_stall_out = 1'b1;
            MEM_DONE: if (load_p1) mem_result_out = result_p2;
            default: ;
        endcase
    end

    assign proc2mem_req      = req_p1;
    assign proc2mem_we       = we_p1;
    assign proc2mem_addr     = addr_p1;
    assign proc2mem_wdata    = wdata_p1;
    assign proc2mem_be       = be_p1;
    assign mem_bus_error_out = (state == MEM_DONE) & bus_err_p2;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads/stores, misalignment, timeout and mid-access reset.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [31:0] alu_result;
    logic [31:0] rega;
    logic [2:0]  funct3;
    logic        rd_mem;
    logic        wr_mem;
    logic        valid_inst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] result;
    logic        stall;
    logic        misaligned;
    logic        bus_error;

    int checks = 0;
    int errors = 0;
    int stalls;
    int reqs;

    mem_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .ex_mem_alu_result  (alu_result),
        .ex_mem_rega        (rega),
        .ex_mem_funct3      (funct3),
        .ex_mem_rd_mem      (rd_mem),
        .ex_mem_wr_mem      (wr_mem),
        .ex_mem_valid_inst  (valid_inst),
        .proc2mem_req       (req),
        .proc2mem_we        (we),
        .proc2mem_addr      (addr),
        .proc2mem_wdata     (wdata),
        .proc2mem_be        (be),
        .mem2proc_ack       (ack),
        .mem2proc_rdata     (rdata),
        .mem_result_out     (result),
        .mem_stall_out      (stall),
        .mem_misaligned_out (misaligned),
        .mem_bus_error_out  (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Single access acknowledged in its first BUSY cycle; returns one cycle after DONE, in IDLE
    task automatic fast_access(input string tag, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] sdata, input logic [31:0] rd_word,
                               input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                               input logic [31:0] exp_res);
        valid_inst = 1'b1;
        rd_mem     = rd;
        wr_mem     = wr;
        funct3     = f3;
        alu_result = a;
        rega       = sdata;
        #1;
        chk({tag, " start stall"}, 32'(stall), 32'd1);
        chk({tag, " start req"}, 32'(req), 32'd0);
        step();
        chk({tag, " busy req"}, 32'(req), 32'd1);
        chk({tag, " addr"}, addr, {a[31:2], 2'b00});
        chk({tag, " be"}, 32'(be), 32'(exp_be));
        chk({tag, " we"}, 32'(we), 32'(wr & ~rd));
        chk({tag, " wdata"}, wdata, exp_wdata);
        ack   = 1'b1;
        rdata = rd_word;
        step();
        ack   = 1'b0;
        #1;
        chk({tag, " done req"}, 32'(req), 32'd0);
        chk({tag, " done stall"}, 32'(stall), 32'd0);
        chk({tag, " result"}, result, exp_res);
        valid_inst = 1'b0;
        rd_mem     = 1'b0;
        wr_mem     = 1'b0;
        step();
        chk({tag, " idle req"}, 32'(req), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        alu_result = '0;
        rega       = '0;
        funct3     = '0;
        rd_mem     = 1'b0;
        wr_mem     = 1'b0;
        valid_inst = 1'b0;
        ack        = 1'b0;
        rdata      = '0;
        #1;
        chk("reset req", 32'(req), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset addr", addr, 32'd0);
        chk("reset be", 32'(be), 32'd0);
        chk("reset wdata", wdata, 32'd0);
        chk("reset bus_error", 32'(bus_error), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // ALU op passes straight through
        valid_inst = 1'b1;
        alu_result = 32'h0000_1234;
        #1;
        chk("alu result", result, 32'h0000_1234);
        chk("alu stall", 32'(stall), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("alu req", 32'(req), 32'd0);
        end
        valid_inst = 1'b0;

        fast_access("lb",  1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FFFF,
                    4'b1000, 32'h0000_0000, 32'hFFFF_FF80);
        fast_access("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_FFFF,
                    4'b1000, 32'h0000_0000, 32'h0000_0080);
        fast_access("lh",  1'b1, 1'b0, 3'b001, 32'h0000_7002, 32'h0, 32'h8001_1234,
                    4'b1100, 32'h0000_0000, 32'hFFFF_8001);
        fast_access("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_7002, 32'h0, 32'h8001_1234,
                    4'b1100, 32'h0000_0000, 32'h0000_8001);
        fast_access("lb pos", 1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0, 32'hFFFF_FF7F,
                    4'b0001, 32'h0000_0000, 32'h0000_007F);
        fast_access("lw",  1'b1, 1'b0, 3'b010, 32'h0000_9004, 32'h0, 32'hCAFE_F00D,
                    4'b1111, 32'h0000_0000, 32'hCAFE_F00D);
        fast_access("sb",  1'b0, 1'b1, 3'b000, 32'h0000_6001, 32'h1234_5678, 32'h0,
                    4'b0010, 32'h7878_7878, 32'h0000_6001);
        fast_access("sw",  1'b0, 1'b1, 3'b010, 32'h0000_8000, 32'hDEAD_BEEF, 32'h0,
                    4'b1111, 32'hDEAD_BEEF, 32'h0000_8000);
        fast_access("rd+wr load", 1'b1, 1'b1, 3'b010, 32'h0000_A000, 32'h1111_1111,
                    32'h5555_AAAA, 4'b1111, 32'h1111_1111, 32'h5555_AAAA);

        // Halfword store acked in the fourth BUSY cycle
        valid_inst = 1'b1;
        rd_mem     = 1'b0;
        wr_mem     = 1'b1;
        funct3     = 3'b001;
        alu_result = 32'h0000_2002;
        rega       = 32'hAAAA_BEEF;
        #1;
        stalls = 0;
        for (int c = 0; c < 12; c++) begin
            if (!stall) break;
            stalls++;
            if (c == 2) begin
                chk("sh addr", addr, 32'h0000_2000);
                chk("sh be", 32'(be), 32'h0000_000C);
                chk("sh wdata", wdata, 32'hBEEF_BEEF);
                chk("sh we", 32'(we), 32'd1);
                chk("sh req", 32'(req), 32'd1);
            end
            ack = (c == 4);
            step();
            ack = 1'b0;
            #1;
        end
        chk("sh stall cycles", 32'(stalls), 32'd5);
        chk("sh done req", 32'(req), 32'd0);
        chk("sh done result", result, 32'h0000_2002);
        valid_inst = 1'b0;
        wr_mem     = 1'b0;
        step();

        // Misaligned word load never reaches memory
        valid_inst = 1'b1;
        rd_mem     = 1'b1;
        funct3     = 3'b010;
        alu_result = 32'h0000_3001;
        #1;
        chk("mis flag", 32'(misaligned), 32'd1);
        chk("mis req", 32'(req), 32'd0);
        chk("mis stall", 32'(stall), 32'd0);
        chk("mis result", result, 32'hbaad_beef);
        step();
        chk("mis req later", 32'(req), 32'd0);
        valid_inst = 1'b0;
        rd_mem     = 1'b0;
        #1;
        chk("mis flag cleared", 32'(misaligned), 32'd0);

        // Load with no ack runs into the timeout
        valid_inst = 1'b1;
        rd_mem     = 1'b1;
        funct3     = 3'b010;
        alu_result = 32'h0000_4000;
        #1;
        step();
        reqs = 0;
        for (int c = 0; c < 40; c++) begin
            if (!req) break;
            reqs++;
            step();
        end
        chk("timeout req cycles", 32'(reqs), 32'd16);
        chk("timeout bus_error", 32'(bus_error), 32'd1);
        chk("timeout result", result, 32'd0);
        chk("timeout stall", 32'(stall), 32'd0);
        valid_inst = 1'b0;
        rd_mem     = 1'b0;
        step();
        chk("bus_error after done", 32'(bus_error), 32'd0);

        // Reset in the second BUSY cycle abandons the access
        valid_inst = 1'b1;
        rd_mem     = 1'b1;
        funct3     = 3'b010;
        alu_result = 32'h0000_5000;
        #1;
        step();
        step();
        chk("pre-reset req", 32'(req), 32'd1);
        rst = 1'b0;
        #1;
        chk("async reset req", 32'(req), 32'd0);
        chk("async reset bus_error", 32'(bus_error), 32'd0);
        valid_inst = 1'b0;
        rd_mem     = 1'b0;
        #1;
        chk("reset idle stall", 32'(stall), 32'd0);
        step();
        rst = 1'b1;
        ack = 1'b1;
        #1;
        step();
        ack = 1'b0;
        #1;
        chk("stray ack req", 32'(req), 32'd0);
        chk("stray ack stall", 32'(stall), 32'd0);
        chk("stray ack bus_error", 32'(bus_error), 32'd0);
        chk("stray ack result", result, 32'h0000_5000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
